alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq_mul.sv | 51 +++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq slice: opcode map, FSM state
// encoding and bit positions within the {N, Z, C, V} flag vector.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq. The master offers operands
// and consumes results; the slave (the ALU) accepts operations and holds
// results until they are taken.
interface alu_seq_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic [W-1:0] z_hi;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, z, z_hi, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, z, z_hi, flags
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// start loads the operands; after W steps done pulses alongside the final
// product, which is presented combinationally so the caller can register it
// on the same edge as the last iteration.
module alu_seq_mul #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           step,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int unsigned CW = $clog2(W);

  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc_next;

  // Partial-product accumulation and terminal-count detection
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
    done     = step && (cnt == CW'(W - 1));
    product  = acc_next;
  end

  // Operand load on start, one shift-add iteration per enabled step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{W{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake on both sides. Single-cycle ops
// register their result one edge after acceptance; MUL runs an iterative
// multiplier. Define ALU_SEQ_MUL_EN to build the multi-cycle multiplier;
// without it op 111 returns zero in one cycle and no BUSY logic exists.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  alu_seq_if.slave bus
);
  localparam int unsigned SW = $clog2(W);

  state_t       state;
  state_t       state_next;
  logic         in_ready_c;
  logic         load_alu;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W:0]   shl;
  logic [W-1:0] alu_lo;
  logic         alu_c;
  logic         alu_v;
  logic [3:0]   alu_flags;
  logic [W-1:0] z_r;
  logic [W-1:0] z_hi_r;
  logic [3:0]   flags_r;

`ifdef ALU_SEQ_MUL_EN
  logic           mul_start;
  logic           mul_step;
  logic           mul_done;
  logic           load_mul;
  logic [2*W-1:0] mul_prod;
  logic [3:0]     mul_flags;

  assign mul_step = en && (state == S_BUSY);

  alu_seq_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .step    (mul_step),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Flags for the completed product
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[W-1];
    mul_flags[FLAG_Z] = (mul_prod[W-1:0] == '0);
    mul_flags[FLAG_C] = (mul_prod[2*W-1:W] != '0);
  end
`endif

  // Single-cycle datapath and flags; MUL yields zero here (only used when
  // the multiplier is not built)
  always_comb begin
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    diff   = {1'b0, bus.a} - {1'b0, bus.b};
    shl    = {1'b0, bus.a} << bus.b[SW-1:0];
    alu_lo = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    case (op_t'(bus.op))
      OP_ADD: begin
        alu_lo = sum[W-1:0];
        alu_c  = sum[W];
        alu_v  = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      OP_SUB: begin
        alu_lo = diff[W-1:0];
        alu_c  = ~diff[W];
        alu_v  = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      OP_AND: alu_lo = bus.a & bus.b;
      OP_OR:  alu_lo = bus.a | bus.b;
      OP_XOR: alu_lo = bus.a ^ bus.b;
      OP_NOT: alu_lo = ~bus.a;
      // bit W of the widened shift is the last bit pushed out; zero for shift 0
      OP_SHL: begin
        alu_lo = shl[W-1:0];
        alu_c  = shl[W];
      end
      OP_MUL: alu_lo = '0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_lo[W-1];
    alu_flags[FLAG_Z] = (alu_lo == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  // Next-state, acceptance and load decisions; en gates every transition
  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    load_alu   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mul_start  = 1'b0;
    load_mul   = 1'b0;
`endif
    case (state)
      S_IDLE: in_ready_c = en;
      S_HOLD: begin
        in_ready_c = en && bus.out_ready;
        if (en && bus.out_ready) state_next = S_IDLE;
      end
      S_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_next = S_HOLD;
          load_mul   = 1'b1;
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
    // Acceptance in HOLD overrides the return to IDLE (back-to-back delivery)
    if (in_ready_c && bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
      if (op_t'(bus.op) == OP_MUL) begin
        state_next = S_BUSY;
        mul_start  = 1'b1;
      end else begin
        state_next = S_HOLD;
        load_alu   = 1'b1;
      end
`else
      state_next = S_HOLD;
      load_alu   = 1'b1;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Result registers, held stable until the next load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_r     <= '0;
      z_hi_r  <= '0;
      flags_r <= '0;
    end else if (load_alu) begin
      z_r     <= alu_lo;
      z_hi_r  <= '0;
      flags_r <= alu_flags;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (load_mul) begin
      z_r     <= mul_prod[W-1:0];
      z_hi_r  <= mul_prod[2*W-1:W];
      flags_r <= mul_flags;
    end
`endif
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == S_HOLD);
  assign bus.z         = z_r;
  assign bus.z_hi      = z_hi_r;
  assign bus.flags     = flags_r;
endmodule
